// File: rtl/j1_loader_pkg.sv
// Shared types and codes for the J1 byte-stream boot loader.
package j1_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_CMD, ST_ADDR_H, ST_ADDR_L, ST_CNT_H,
    ST_CNT_L, ST_DAT_H, ST_DAT_L, ST_CSUM, ST_ACK
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] CMD_HALT  = 8'h03;

  localparam logic [7:0] ACK_OK  = 8'h4B;
  localparam logic [7:0] ERR_CMD = 8'hE1;
  localparam logic [7:0] ERR_TMO = 8'hE2;
  localparam logic [7:0] ERR_SUM = 8'hE3;

  // J1 program memory is word-addressed through a byte address, so bit0 is dropped.
  function automatic logic [15:0] word_addr(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo[7:1], 1'b0};
  endfunction

endpackage

// File: rtl/j1_loader_timeout.sv
// Inter-byte idle counter; expired stays high once TIMEOUT idle cycles have elapsed.
module loader_timeout #(
  parameter int TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != W'(TIMEOUT))) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == W'(TIMEOUT));

endmodule

// File: rtl/j1_loader.sv
// Frame parser that loads J1 program memory over the programming port and owns the CPU reset.
module j1_loader
  import j1_loader_pkg::*;
#(
  parameter logic [7:0] SYNC     = 8'hA5,
  parameter int         TIMEOUT  = 100000,
  parameter logic       BOOT_RUN = 1'b0
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] pgm_addr,
  output logic [15:0] pgm_data,
  output logic        pgm_we,
  output logic        cpu_rst_o,
  output logic        load_err
);

  state_t      state;
  logic [7:0]  csum;
  logic [7:0]  cmd;
  logic [7:0]  addr_hi;
  logic [7:0]  cnt_hi;
  logic [7:0]  dat_hi;
  logic [15:0] cnt;
  logic [7:0]  sum_next;
  logic        accept;
  logic        tmo_en;
  logic        tmo_expired;

  assign rx_ready = (state != ST_ACK);
  assign accept   = rx_valid && rx_ready;
  assign tmo_en   = (state != ST_IDLE) && (state != ST_ACK);
  assign sum_next = csum + rx_data;

  loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (sys_clk_i),
    .rst     (sys_rst_i),
    .clear   (accept),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state     <= ST_IDLE;
      csum      <= 8'h00;
      cmd       <= 8'h00;
      addr_hi   <= 8'h00;
      cnt_hi    <= 8'h00;
      dat_hi    <= 8'h00;
      cnt       <= 16'h0000;
      pgm_addr  <= 16'h0000;
      pgm_data  <= 16'h0000;
      pgm_we    <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      load_err  <= 1'b0;
      cpu_rst_o <= ~BOOT_RUN;
    end else begin
      pgm_we <= 1'b0;
      // The address advances on the edge that ends the write strobe.
      if (pgm_we) begin
        pgm_addr <= pgm_addr + 16'd2;
      end
      case (state)
        ST_IDLE: begin
          if (accept && (rx_data == SYNC)) begin
            csum  <= 8'h00;
            state <= ST_CMD;
          end
        end
        ST_ACK: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          if (accept) begin
            csum <= sum_next;
            case (state)
              ST_CMD: begin
                cmd <= rx_data;
                case (rx_data)
                  CMD_WRITE: begin
                    cpu_rst_o <= 1'b1;
                    state     <= ST_ADDR_H;
                  end
                  CMD_RUN, CMD_HALT: state <= ST_CSUM;
                  default: begin
                    state    <= ST_ACK;
                    tx_valid <= 1'b1;
                    tx_data  <= ERR_CMD;
                    load_err <= 1'b1;
                  end
                endcase
              end
              ST_ADDR_H: begin
                addr_hi <= rx_data;
                state   <= ST_ADDR_L;
              end
              ST_ADDR_L: begin
                pgm_addr <= word_addr(addr_hi, rx_data);
                state    <= ST_CNT_H;
              end
              ST_CNT_H: begin
                cnt_hi <= rx_data;
                state  <= ST_CNT_L;
              end
              ST_CNT_L: begin
                cnt   <= {cnt_hi, rx_data};
                state <= ({cnt_hi, rx_data} == 16'h0000) ? ST_CSUM : ST_DAT_H;
              end
              ST_DAT_H: begin
                dat_hi <= rx_data;
                state  <= ST_DAT_L;
              end
              ST_DAT_L: begin
                pgm_data <= {dat_hi, rx_data};
                pgm_we   <= 1'b1;
                cnt      <= cnt - 16'd1;
                state    <= (cnt == 16'd1) ? ST_CSUM : ST_DAT_H;
              end
              ST_CSUM: begin
                state    <= ST_ACK;
                tx_valid <= 1'b1;
                if (sum_next != 8'h00) begin
                  tx_data  <= ERR_SUM;
                  load_err <= 1'b1;
                end else begin
                  tx_data  <= ACK_OK;
                  load_err <= 1'b0;
                  if (cmd == CMD_RUN) begin
                    cpu_rst_o <= 1'b0;
                  end else begin
                    cpu_rst_o <= 1'b1;
                  end
                end
              end
              default: state <= ST_IDLE;
            endcase
          end else if (tmo_expired) begin
            state    <= ST_ACK;
            tx_valid <= 1'b1;
            tx_data  <= ERR_TMO;
            load_err <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_j1_loader.sv
// Directed frame table plus hand-written timeout, ack-hold and mid-frame reset sequences.
module tb_j1_loader;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] pgm_addr;
  logic [15:0] pgm_data;
  logic        pgm_we;
  logic        cpu_rst;
  logic        load_err;

  int checks = 0;
  int failures = 0;
  logic [31:0] wq[$];

  j1_loader #(.SYNC(8'hA5), .TIMEOUT(TMO), .BOOT_RUN(1'b0)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .pgm_addr  (pgm_addr),
    .pgm_data  (pgm_data),
    .pgm_we    (pgm_we),
    .cpu_rst_o (cpu_rst),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pgm_we === 1'b1) wq.push_back({pgm_addr, pgm_data});
  end

  typedef struct packed {
    logic [127:0] bytes;
    logic [7:0]   len;
    logic [7:0]   ack;
    logic         rst;
    logic         err;
    logic [1:0]   nwr;
    logic [31:0]  w0;
    logic [31:0]  w1;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_ack(input string name, input logic [7:0] exp, input int bound);
    int n = 0;
    while (tx_valid !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, {31'd0, tx_valid}, 32'd1);
    check({name, "_code"}, {24'd0, tx_data}, {24'd0, exp});
    @(negedge clk);
    tx_ready = 1'b1;
    @(posedge clk);
    #1 tx_ready = 1'b0;
    @(negedge clk);
    check({name, "_drop"}, {31'd0, tx_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;

    vt[0] = '{128'h11_22_A5_01_00_10_00_02_80_05_70_0C_EC, 8'd13, 8'h4B, 1'b1, 1'b0, 2'd2, 32'h0010_8005, 32'h0012_700C};
    vt[1] = '{128'hA5_02_FE, 8'd3, 8'h4B, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0};
    vt[2] = '{128'hA5_03_FD, 8'd3, 8'h4B, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0};
    vt[3] = '{128'hA5_01_00_10_00_02_80_05_70_0C_ED, 8'd11, 8'hE3, 1'b1, 1'b1, 2'd2, 32'h0010_8005, 32'h0012_700C};
    vt[4] = '{128'hA5_02_FE, 8'd3, 8'h4B, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0};
    vt[5] = '{128'hA5_01_FF_FF_00_02_12_34_56_78_EB, 8'd11, 8'h4B, 1'b1, 1'b0, 2'd2, 32'hFFFE_1234, 32'h0000_5678};
    vt[6] = '{128'hA5_07, 8'd2, 8'hE1, 1'b1, 1'b1, 2'd0, 32'h0, 32'h0};
    vt[7] = '{128'h00_A5_03_FD, 8'd4, 8'h4B, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0};
    vt[8] = '{128'hA5_01_00_20_00_00_DF, 8'd7, 8'h4B, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pgm_we", {31'd0, pgm_we}, 32'd0);
    check("rst_pgm_addr", {16'd0, pgm_addr}, 32'd0);
    check("rst_pgm_data", {16'd0, pgm_data}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_load_err", {31'd0, load_err}, 32'd0);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      wq.delete();
      for (int j = 0; j < int'(vt[i].len); j++)
        send(vt[i].bytes[8*(int'(vt[i].len) - 1 - j) +: 8]);
      wait_ack($sformatf("row%0d_ack", i), vt[i].ack, 30);
      repeat (2) @(negedge clk);
      check($sformatf("row%0d_cpu_rst", i), {31'd0, cpu_rst}, {31'd0, vt[i].rst});
      check($sformatf("row%0d_load_err", i), {31'd0, load_err}, {31'd0, vt[i].err});
      check($sformatf("row%0d_nwr", i), wq.size(), {30'd0, vt[i].nwr});
      if (vt[i].nwr >= 2'd1) check($sformatf("row%0d_w0", i), (wq.size() >= 1) ? wq[0] : 32'hx, vt[i].w0);
      if (vt[i].nwr >= 2'd2) check($sformatf("row%0d_w1", i), (wq.size() >= 2) ? wq[1] : 32'hx, vt[i].w1);
    end

    // Timeout inside WRITE header, then a stalled ack sink.
    wq.delete();
    send(8'hA5); send(8'h01); send(8'h00); send(8'hFF);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_early", {31'd0, tx_valid}, 32'd0);
    begin
      int n = 0;
      while (tx_valid !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    check("tmo_valid", {31'd0, tx_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", k), {31'd0, tx_valid}, 32'd1);
      check($sformatf("hold%0d_data", k), {24'd0, tx_data}, 32'h0000_00E2);
      check($sformatf("hold%0d_rx_ready", k), {31'd0, rx_ready}, 32'd0);
    end
    wait_ack("tmo_ack", 8'hE2, 5);
    check("tmo_load_err", {31'd0, load_err}, 32'd1);
    check("tmo_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("tmo_no_write", wq.size(), 32'd0);

    // Clear the CPU reset first so the mid-frame reset value is observable.
    send(8'hA5); send(8'h02); send(8'hFE);
    wait_ack("pre_run_ack", 8'h4B, 30);
    check("pre_run_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    // Reset between DAT_H and DAT_L.
    wq.delete();
    send(8'hA5); send(8'h01); send(8'h00); send(8'h40); send(8'h00); send(8'h01); send(8'hAB);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("mrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("mrst_pgm_addr", {16'd0, pgm_addr}, 32'd0);
    send(8'hCD);
    repeat (5) @(negedge clk);
    check("mrst_no_write", wq.size(), 32'd0);
    check("mrst_no_ack", {31'd0, tx_valid}, 32'd0);
    send(8'hA5); send(8'h02); send(8'hFE);
    wait_ack("mrst_run_ack", 8'h4B, 30);
    check("mrst_run_cpu_rst", {31'd0, cpu_rst}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/j1_loader.md
Name: j1_loader

Overview:
- Byte-stream boot loader that drives the J1 programming port (pgm_addr/pgm_data/pgm_we) and owns the CPU reset.
- Sits between a byte source (UART RX or host FIFO) and the J1 core. Parses framed commands, streams 16-bit words into program memory, and returns a one-byte status per frame on a TX byte stream.
- Holds the CPU in reset while loading, because pgm_we steals the instruction-fetch port.

Parameters:
- SYNC, 8'hA5, frame start byte.
- TIMEOUT, 100000, idle cycles allowed between bytes inside a frame before it is aborted.
- BOOT_RUN, 0, value of ~cpu_rst_o after reset (0 = CPU held in reset until a RUN frame).

Ports:
- sys_clk_i  in  1  clock
- sys_rst_i  in  1  synchronous active-high reset
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte on cycles where rx_valid & rx_ready
- tx_data  out  8  status byte
- tx_valid  out  1  status byte valid
- tx_ready  in  1  sink accepts status byte
- pgm_addr  out  16  byte address to J1 (bit0 always 0)
- pgm_data  out  16  instruction word
- pgm_we  out  1  one-cycle write strobe
- cpu_rst_o  out  1  to J1 sys_rst_i
- load_err  out  1  sticky: last completed frame failed

Behaviour:
- Clock and reset: one clock, sys_clk_i. Reset is synchronous and active-high on sys_rst_i.
- Reset values:
  - state=IDLE, pgm_we=0, pgm_addr=0, pgm_data=0
  - tx_valid=0, tx_data=0, load_err=0
  - cpu_rst_o=~BOOT_RUN
  - checksum=0, timeout counter=0
- Reset mid-frame aborts the frame silently; no ack is sent.
- Frame format: SYNC, CMD, payload, CSUM. The 8-bit sum of CMD through CSUM inclusive must equal 0x00.
- Commands:
  - 0x01 WRITE: payload is ADDR_H, ADDR_L, CNT_H, CNT_L, then CNT words, each sent hi byte then lo byte.
  - 0x02 RUN: no payload.
  - 0x03 HALT: no payload.
- States: IDLE, CMD, ADDR_H, ADDR_L, CNT_H, CNT_L, DAT_H, DAT_L, CSUM, ACK.
  - One byte is consumed per state transition; back-to-back bytes are accepted every cycle.
- IDLE:
  - Non-SYNC bytes are discarded silently.
  - SYNC clears the checksum and moves to CMD.
- CMD:
  - 0x01: assert cpu_rst_o immediately (registered, effective the next cycle), then go to ADDR_H.
  - 0x02 or 0x03: go to CSUM.
  - Any other value: go to ACK with code 0xE1.
- ADDR_L: load pgm_addr = {ADDR_H, ADDR_L} with bit0 forced to 0.
- CNT_L: load the 16-bit word counter. If CNT=0, go straight to CSUM with no writes.
- DAT_L accepted at edge k:
  - pgm_data={hi,lo} is registered; pgm_we=1 during cycle k+1 only, with pgm_addr stable.
  - Address advance: pgm_addr += 2 (mod 2^16) at edge k+1, after the strobe.
  - Counter: decrement; if it reaches 0, go to CSUM, else to DAT_H.
- SYNC bytes inside a frame are ordinary data; there is no resync.
- CSUM:
  - Sum != 0: ack 0xE3, load_err=1, no command effect. Writes already made stay in memory and the CPU remains in reset.
  - Sum OK: RUN sets cpu_rst_o=0; HALT sets cpu_rst_o=1; WRITE leaves cpu_rst_o=1. Ack 0x4B, load_err=0.
- Timeout:
  - The counter clears on every accepted byte and counts only in states other than IDLE and ACK.
  - Reaching TIMEOUT goes to ACK with 0xE2 and load_err=1.
- ACK:
  - rx_ready=0, tx_valid=1, tx_data=code, held stable until tx_ready.
  - On the handshake cycle, tx_valid drops next cycle and the state returns to IDLE.
- rx_ready=1 in every state except ACK.
- Simultaneous rx_valid with a timeout expiry in the same cycle: the byte wins and the counter clears.

Decomposition:
- Shared package j1_loader_pkg: state enum, command codes (CMD_WRITE/RUN/HALT), ack codes (ACK_OK=0x4B, ERR_CMD=0xE1, ERR_TMO=0xE2, ERR_SUM=0xE3).
- One natural sub-module: loader_timeout (clear/enable inputs, expired output, parameter TIMEOUT).

Test Plan:
- Reset, then stream A5 01 00 10 00 02 80 05 70 0C EC:
  - pgm_we pulses twice: (0x0010, 0x8005) and (0x0012, 0x700C).
  - cpu_rst_o=1 throughout; ack 0x4B; load_err=0.
- Stream A5 02 FE: cpu_rst_o falls after CSUM; ack 0x4B. Then A5 03 FD: cpu_rst_o=1; ack 0x4B.
- Same WRITE frame with last byte 0xED: both writes still occur; ack 0xE3; load_err=1; a following RUN with correct checksum clears load_err.
- A5 01 00 FF then stall TIMEOUT cycles: ack 0xE2 with no pgm_we. Hold tx_ready=0 for 5 cycles: tx_valid/tx_data held and rx_ready=0.
- Edge cases:
  - Start address 0xFFFF with CNT=2 writes to 0xFFFE then 0x0000.
  - A5 07 00 gives ack 0xE1.
  - Garbage 11 22 before A5 is ignored.
- Assert sys_rst_i between DAT_H and DAT_L: no pgm_we, no ack, state IDLE, cpu_rst_o=~BOOT_RUN.
